// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand bundle for seq_magnitude_comparator.
// The requester uses the master modport and the comparator uses the slave modport.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             G;
  logic             E;
  logic             L;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, G, E, L
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, G, E, L
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle G/E/L magnitude comparator. It compares DIGIT bits per clock, starting with the MSB digit.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish on the first differing digit instead of always taking N cycles.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_magnitude_comparator_if.slave   bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a, op_b;
  logic             gt, lt;
  logic             gt_nxt, lt_nxt;
  logic             finish;
  logic             done_q, g_q, e_q, l_q;
  logic [DIGIT-1:0] digit_a, digit_b;

  assign digit_a = op_a[int'(idx)*DIGIT +: DIGIT];
  assign digit_b = op_b[int'(idx)*DIGIT +: DIGIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    gt_nxt     = gt;
    lt_nxt     = lt;
    finish     = 1'b0;
    case (state)
      IDLE: if (bus.start) next_state = CMP;
      CMP: begin
        // Only the first differing digit decides the result. Later digits are masked off.
        if (!(gt || lt)) begin
          gt_nxt = digit_a > digit_b;
          lt_nxt = digit_a < digit_b;
        end
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
        finish = (idx == '0) || (!(gt || lt) && (digit_a != digit_b));
`else
        finish = (idx == '0);
`endif
        if (finish) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every register here resets asynchronously, so an abort returns all outputs to zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      done_q <= 1'b0;
      g_q    <= 1'b0;
      e_q    <= 1'b0;
      l_q    <= 1'b0;
    end else begin
      done_q <= (state == CMP) && finish;
      case (state)
        IDLE: if (bus.start) begin
          op_a <= bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
          op_b <= bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
          gt   <= 1'b0;
          lt   <= 1'b0;
          idx  <= IDX_LAST;
        end
        CMP: begin
          gt  <= gt_nxt;
          lt  <= lt_nxt;
          idx <= idx - 1'b1;
          if (finish) begin
            g_q <= gt_nxt;
            e_q <= !gt_nxt && !lt_nxt;
            l_q <= lt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == CMP);
  assign bus.done = done_q;
  assign bus.G    = g_q;
  assign bus.E    = e_q;
  assign bus.L    = l_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed self-checking bench for seq_magnitude_comparator with WIDTH=16 and DIGIT=4.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_seq_magnitude_comparator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seq_magnitude_comparator_if #(.WIDTH(16)) bus ();

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge. On return, the bench sits one falling edge after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sm);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.signed_mode = sm; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat counts edges from the accepting edge until done is seen. Sampling stops after a bounded budget.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy/done/G/E/L=%b expected 00000",
               {bus.busy, bus.done, bus.G, bus.E, bus.L});
    end
  endtask

  task automatic test_equal;
    int lat, bc;
    launch(16'h1234, 16'h1234, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL eq_latency: got %0d expected 4", lat); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL eq_busy_cycles: got %0d expected 4", bc); end
    checks++;
    if ({bus.G, bus.E, bus.L, bus.busy} !== 4'b0100) begin
      errors++; $display("FAIL eq_result: got G/E/L/busy=%b expected 0100", {bus.G, bus.E, bus.L, bus.busy});
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.E} !== 2'b01) begin
      errors++; $display("FAIL eq_done_width: got done/E=%b expected 01", {bus.done, bus.E});
    end
  endtask

  // Table columns: a, b, signed_mode, expected {G,E,L}, latency without early exit, latency with early exit.
  task automatic test_signed_and_early;
    logic [15:0] ta  [5] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hA000, 16'h1235};
    logic [15:0] tb_ [5] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h1000, 16'h1234};
    logic        tsm [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  tgel[5] = '{3'b100, 3'b001, 3'b001, 3'b100, 3'b100};
    int          tlat[5] = '{4, 4, 4, 4, 4};
    int          tee [5] = '{1, 1, 1, 1, 4};
    int lat, bc, exp_lat;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb_[i], tsm[i]);
      wait_done(lat, bc);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
      exp_lat = tee[i];
`else
      exp_lat = tlat[i];
`endif
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, exp_lat);
      end
      checks++;
      if ({bus.G, bus.E, bus.L} !== tgel[i]) begin
        errors++; $display("FAIL vec%0d_gel: got %b expected %b", i, {bus.G, bus.E, bus.L}, tgel[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, k;
    @(negedge clk);
    bus.a = 16'd5; bus.b = 16'd9; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 16'd9; bus.b = 16'd5;           // start stays high during busy and must be ignored
    wait_done(lat, bc);
    checks++;
    if (lat !== 4 || {bus.G, bus.E, bus.L} !== 3'b001) begin
      errors++; $display("FAIL b2b_first: got lat=%0d gel=%b expected lat=4 gel=001", lat, {bus.G, bus.E, bus.L});
    end
    @(negedge clk);                          // start was high at the done-cycle edge
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy); end
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      checks++;
      if ({bus.G, bus.E, bus.L} !== 3'b001) begin
        errors++; $display("FAIL b2b_hold: got gel=%b expected 001", {bus.G, bus.E, bus.L});
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 4 || {bus.G, bus.E, bus.L} !== 3'b100) begin
      errors++; $display("FAIL b2b_second: got cycles=%0d gel=%b expected cycles=4 gel=100", k, {bus.G, bus.E, bus.L});
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, dseen, exp_lat;
    launch(16'h4321, 16'h4320, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
      errors++; $display("FAIL abort_outputs: got busy/done/G/E/L=%b expected 00000",
                         {bus.busy, bus.done, bus.G, bus.E, bus.L});
    end
    dseen = 0;
    repeat (3) begin @(negedge clk); if (bus.done === 1'b1) dseen++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.done === 1'b1) dseen++; end
    checks++;
    if (dseen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dseen); end
    launch(16'h0010, 16'h0100, 1'b0);
    wait_done(lat, bc);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 4;
`endif
    checks++;
    if (lat !== exp_lat || {bus.G, bus.E, bus.L} !== 3'b001) begin
      errors++; $display("FAIL post_abort: got lat=%0d gel=%b expected lat=%0d gel=001",
                         lat, {bus.G, bus.E, bus.L}, exp_lat);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_equal();
    test_signed_and_early();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
